axi2wb_wb_issuer: RTL and testbench

- Downstream consumer of the AXI-side command FIFO in the axi2wb interconnect wrapper.
- Pops one command word per transaction and runs it as a single Wishbone classic cycle.
- Guards each cycle with a timeout counter.
- Pushes exactly one response word per command into the response FIFO that feeds the AXI R/B channels.

---
 rtl/axi2wb_wb_issuer.sv | 145 ++++++++++++++
 tb/tb_axi2wb_wb_issuer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2wb_wb_issuer.sv
// Issues one Wishbone classic cycle for each command popped from the AXI-side
// command FIFO, and returns exactly one response word for it, with a timeout guard.
module axi2wb_wb_issuer #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int IDW     = 4,
  parameter int TIMEOUT = 255,
  parameter int CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            cmd_empty_i,
  output logic            cmd_pop_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic [IDW-1:0]  cmd_id_i,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            rsp_full_i,
  output logic            rsp_push_o,
  output logic [DW-1:0]   rsp_data_o,
  output logic            rsp_we_o,
  output logic            rsp_err_o,
  output logic [IDW-1:0]  rsp_id_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam bit            TO_EN     = (TIMEOUT > 32'sd0);
  localparam int            TO_LAST_I = TO_EN ? (TIMEOUT - 32'sd1) : 32'sd0;
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_LAST_I);

  state_e         state_r;
  logic [CW-1:0]  cnt_r;
  logic [IDW-1:0] id_r;
  logic           pop_s;
  logic           push_s;
  logic           timeout_s;
  logic           term_s;

  // Pop/push handshakes are combinational on state; both are held off by reset and flush.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (rst_ni && !flush_i) begin
      case (state_r)
        IDLE:    pop_s  = !cmd_empty_i;
        RESP:    push_s = !rsp_full_i;
        default: begin
          pop_s  = 1'b0;
          push_s = 1'b0;
        end
      endcase
    end else begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end
  end

  assign timeout_s  = TO_EN && (cnt_r == TO_LAST);
  assign term_s     = wb_ack_i || wb_err_i || timeout_s;
  assign cmd_pop_o  = pop_s;
  assign rsp_push_o = push_s;

  // Transaction FSM with registered bus and response fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      id_r       <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      rsp_data_o <= '0;
      rsp_we_o   <= 1'b0;
      rsp_err_o  <= 1'b0;
      rsp_id_o   <= '0;
    end else if (flush_i) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            wb_adr_o <= cmd_addr_i;
            wb_dat_o <= cmd_wdata_i;
            wb_sel_o <= cmd_sel_i;
            wb_we_o  <= cmd_we_i;
            id_r     <= cmd_id_i;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cnt_r    <= '0;
            state_r  <= BUS;
          end
        end
        BUS: begin
          if (term_s) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            cnt_r      <= '0;
            rsp_we_o   <= wb_we_o;
            rsp_id_o   <= id_r;
            // Without ack or err the only remaining cause is the timeout.
            rsp_err_o  <= wb_err_i || !wb_ack_i;
            rsp_data_o <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
            state_r    <= RESP;
          end else if (cnt_r != {CW{1'b1}}) begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        RESP: begin
          if (push_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi2wb_wb_issuer.sv
// Randomized bench for axi2wb_wb_issuer: a queue models the command FIFO and each
// response is predicted from the slave behaviour chosen for that transaction.
module tb_axi2wb_wb_issuer;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int IDW     = 4;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 4;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  sel;
    logic [IDW-1:0] id;
  } cmd_t;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i;
  logic           cmd_empty_i;
  logic           cmd_pop_o;
  logic           cmd_we_i;
  logic [AW-1:0]  cmd_addr_i;
  logic [DW-1:0]  cmd_wdata_i;
  logic [SW-1:0]  cmd_sel_i;
  logic [IDW-1:0] cmd_id_i;
  logic [AW-1:0]  wb_adr_o;
  logic [DW-1:0]  wb_dat_o;
  logic [SW-1:0]  wb_sel_o;
  logic           wb_we_o;
  logic           wb_cyc_o;
  logic           wb_stb_o;
  logic [DW-1:0]  wb_dat_i;
  logic           wb_ack_i;
  logic           wb_err_i;
  logic           rsp_full_i;
  logic           rsp_push_o;
  logic [DW-1:0]  rsp_data_o;
  logic           rsp_we_o;
  logic           rsp_err_o;
  logic [IDW-1:0] rsp_id_o;

  cmd_t cmd_q[$];
  int   total = 0;
  int   bad   = 0;

  axi2wb_wb_issuer #(.AW(AW), .DW(DW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .cmd_empty_i(cmd_empty_i), .cmd_pop_o(cmd_pop_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
    .cmd_id_i(cmd_id_i), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .rsp_full_i(rsp_full_i), .rsp_push_o(rsp_push_o),
    .rsp_data_o(rsp_data_o), .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .rsp_id_o(rsp_id_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_head();
    if (cmd_q.size() == 0) begin
      cmd_empty_i = 1'b1;
      cmd_we_i    = 1'b0;
      cmd_addr_i  = '0;
      cmd_wdata_i = '0;
      cmd_sel_i   = '0;
      cmd_id_i    = '0;
    end else begin
      cmd_empty_i = 1'b0;
      cmd_we_i    = cmd_q[0].we;
      cmd_addr_i  = cmd_q[0].addr;
      cmd_wdata_i = cmd_q[0].wdata;
      cmd_sel_i   = cmd_q[0].sel;
      cmd_id_i    = cmd_q[0].id;
    end
  endtask

  task automatic push_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] sel, input logic [IDW-1:0] id);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.sel = sel; c.id = id;
    cmd_q.push_back(c);
    drive_head();
  endtask

  // Waits (bounded) for the pop of the queue head and returns it once the DUT has taken it.
  task automatic take_cmd(output cmd_t c, output bit ok);
    int waited = 0;
    #1;
    while (!cmd_pop_o && waited < 4) begin
      tick();
      waited++;
    end
    check_eq("pop_seen", {63'd0, cmd_pop_o}, 64'd1);
    ok = cmd_pop_o;
    c  = '0;
    if (ok) begin
      tick();
      c = cmd_q.pop_front();
      drive_head();
      check_eq("bus_cyc", {63'd0, wb_cyc_o}, 64'd1);
      check_eq("bus_stb", {63'd0, wb_stb_o}, 64'd1);
      check_eq("bus_adr", {32'd0, wb_adr_o}, {32'd0, c.addr});
      check_eq("bus_dat", {32'd0, wb_dat_o}, {32'd0, c.wdata});
      check_eq("bus_sel", {60'd0, wb_sel_o}, {60'd0, c.sel});
      check_eq("bus_we", {63'd0, wb_we_o}, {63'd0, c.we});
      check_eq("no_pop_bus", {63'd0, cmd_pop_o}, 64'd0);
    end
  endtask

  // One full transaction: slave answers with `kind` after `lat` BUS cycles, then the
  // response FIFO stays full for `full_cyc` cycles.
  task automatic run_txn(input int lat, input int kind, input int full_cyc, input bit late_ack,
                         input bit fix_rd, input logic [DW-1:0] fix_val);
    cmd_t c;
    bit ok;
    int term;
    logic [DW-1:0] rd;
    logic exp_err;
    logic [DW-1:0] exp_data;
    take_cmd(c, ok);
    if (!ok) return;
    term = (kind != K_NONE && lat < TIMEOUT) ? lat : TIMEOUT - 1;
    rd = '0;
    for (int i = 0; i <= term; i++) begin
      wb_dat_i = fix_rd ? fix_val : $urandom();
      check_eq("cyc_held", {63'd0, wb_cyc_o}, 64'd1);
      check_eq("adr_stable", {32'd0, wb_adr_o}, {32'd0, c.addr});
      if (i == lat && kind != K_NONE) begin
        wb_ack_i = (kind != K_ERR);
        wb_err_i = (kind != K_ACK);
        rd       = wb_dat_i;
      end
      tick();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
    check_eq("cyc_drop", {63'd0, wb_cyc_o}, 64'd0);
    check_eq("stb_drop", {63'd0, wb_stb_o}, 64'd0);
    exp_err  = !(kind == K_ACK && lat < TIMEOUT);
    exp_data = (!exp_err && !c.we) ? rd : '0;
    wb_ack_i = late_ack;
    wb_dat_i = $urandom();
    for (int i = 0; i < full_cyc; i++) begin
      rsp_full_i = 1'b1;
      #1;
      check_eq("hold_push", {63'd0, rsp_push_o}, 64'd0);
      check_eq("hold_pop", {63'd0, cmd_pop_o}, 64'd0);
      check_eq("hold_data", {32'd0, rsp_data_o}, {32'd0, exp_data});
      check_eq("hold_err", {63'd0, rsp_err_o}, {63'd0, exp_err});
      tick();
    end
    rsp_full_i = 1'b0;
    #1;
    check_eq("push", {63'd0, rsp_push_o}, 64'd1);
    check_eq("rsp_data", {32'd0, rsp_data_o}, {32'd0, exp_data});
    check_eq("rsp_err", {63'd0, rsp_err_o}, {63'd0, exp_err});
    check_eq("rsp_we", {63'd0, rsp_we_o}, {63'd0, c.we});
    check_eq("rsp_id", {60'd0, rsp_id_o}, {60'd0, c.id});
    tick();
    wb_ack_i = 1'b0;
    check_eq("push_once", {63'd0, rsp_push_o}, 64'd0);
    check_eq("idle_cyc", {63'd0, wb_cyc_o}, 64'd0);
  endtask

  // Aborts a transaction: 0 = flush in BUS, 1 = flush in RESP, 2 = reset in BUS.
  task automatic abort_txn(input int where);
    cmd_t c;
    bit ok;
    take_cmd(c, ok);
    if (!ok) return;
    if (where == 1) begin
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i   = 1'b0;
      rsp_full_i = 1'b1;
      check_eq("resp_cyc", {63'd0, wb_cyc_o}, 64'd0);
    end
    if (where == 2) begin
      rst_ni = 1'b0;
      #1;
      check_eq("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
      check_eq("rst_stb", {63'd0, wb_stb_o}, 64'd0);
      check_eq("rst_adr", {32'd0, wb_adr_o}, 64'd0);
      check_eq("rst_pop", {63'd0, cmd_pop_o}, 64'd0);
      tick();
      check_eq("rst_pop_hold", {63'd0, cmd_pop_o}, 64'd0);
      rst_ni = 1'b1;
      #1;
      check_eq("rst_no_push", {63'd0, rsp_push_o}, 64'd0);
    end else begin
      flush_i    = 1'b1;
      rsp_full_i = 1'b0;
      #1;
      check_eq("flush_push", {63'd0, rsp_push_o}, 64'd0);
      check_eq("flush_pop", {63'd0, cmd_pop_o}, 64'd0);
      tick();
      flush_i = 1'b0;
      check_eq("flush_cyc", {63'd0, wb_cyc_o}, 64'd0);
      check_eq("flush_idle_push", {63'd0, rsp_push_o}, 64'd0);
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    rsp_full_i = 1'b0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_dat_i   = '0;
    drive_head();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("reset_cyc", {63'd0, wb_cyc_o}, 64'd0);
    check_eq("reset_stb", {63'd0, wb_stb_o}, 64'd0);
    check_eq("reset_we", {63'd0, wb_we_o}, 64'd0);
    check_eq("reset_adr", {32'd0, wb_adr_o}, 64'd0);
    check_eq("reset_dat", {32'd0, wb_dat_o}, 64'd0);
    check_eq("reset_sel", {60'd0, wb_sel_o}, 64'd0);
    check_eq("reset_push", {63'd0, rsp_push_o}, 64'd0);
    check_eq("reset_rdata", {32'd0, rsp_data_o}, 64'd0);
    check_eq("reset_rerr", {63'd0, rsp_err_o}, 64'd0);
    check_eq("reset_rwe", {63'd0, rsp_we_o}, 64'd0);
    check_eq("reset_rid", {60'd0, rsp_id_o}, 64'd0);
    rst_ni = 1'b1;
    tick();
    check_eq("empty_no_pop", {63'd0, cmd_pop_o}, 64'd0);

    // Directed cases
    push_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, 4'd3);
    run_txn(2, K_ACK, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    push_cmd(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 4'd5);
    run_txn(0, K_ACK, 0, 1'b0, 1'b0, 32'h0);
    push_cmd(1'b0, 32'h0000_0080, 32'h0, 4'hF, 4'd7);
    run_txn(1, K_BOTH, 0, 1'b0, 1'b0, 32'h0);
    push_cmd(1'b0, 32'h0000_00C0, 32'h0, 4'hF, 4'd9);
    run_txn(0, K_NONE, 0, 1'b0, 1'b0, 32'h0);
    push_cmd(1'b0, 32'h0000_0200, 32'h0, 4'hF, 4'd10);
    push_cmd(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'hF, 4'd11);
    run_txn(1, K_ACK, 5, 1'b1, 1'b0, 32'h0);
    run_txn(0, K_ACK, 0, 1'b0, 1'b0, 32'h0);
    push_cmd(1'b0, 32'h0000_0010, 32'h0, 4'hF, 4'd1);
    push_cmd(1'b1, 32'h0000_0014, 32'hA5A5_5A5A, 4'hC, 4'd2);
    push_cmd(1'b0, 32'h0000_0018, 32'h0, 4'h3, 4'd3);
    for (int i = 0; i < 3; i++) run_txn(0, K_ACK, 0, 1'b0, 1'b0, 32'h0);

    // Aborts: each followed by a normal transaction that must be clean
    for (int w = 0; w < 3; w++) begin
      push_cmd(1'b0, 32'h0000_1000 + 32'(w), 32'h0, 4'hF, 4'(12 + w));
      push_cmd(1'b1, 32'h0000_2000 + 32'(w), 32'h5555_0000 + 32'(w), 4'h5, 4'(4 + w));
      abort_txn(w);
      run_txn(1, K_ACK, 0, 1'b0, 1'b0, 32'h0);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      int kind;
      push_cmd(1'($urandom()), $urandom(), $urandom(), 4'($urandom()), 4'($urandom()));
      r = $urandom_range(0, 99);
      kind = (r < 60) ? K_ACK : (r < 75) ? K_ERR : (r < 85) ? K_BOTH : K_NONE;
      run_txn($urandom_range(0, 5), kind, $urandom_range(0, 3), 1'($urandom()), 1'b0, 32'h0);
    end

    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("final_no_pop", {63'd0, cmd_pop_o}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
